// File: rtl/inst_fetch_buf_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Holds the bus widths, the fetch state encoding and the FIFO entry layout.
package inst_fetch_buf_pkg;

    localparam int INST_ADDR_W    = 32;
    localparam int INST_W         = 32;
    localparam int INST_BUF_DEPTH = 4;
    localparam logic RST_ENABLE   = 1'b1;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]      inst_t;

    // pc occupies the upper half so a raw 64-bit FIFO word reads {pc, inst}
    typedef struct packed {
        inst_addr_t pc;
        inst_t      inst;
    } fetch_entry_t;

    typedef enum logic {
        F_IDLE = 1'b0,
        F_RUN  = 1'b1
    } fetch_state_t;

    function automatic inst_addr_t align_word(input inst_addr_t addr);
        return addr & ~inst_addr_t'(3);
    endfunction

endpackage

// File: rtl/inst_fetch_buf_if.sv
// ROM and decode-side signals of the fetch buffer.
// master = fetch buffer, slave = ROM/decode environment.
interface inst_fetch_buf_if
    import inst_fetch_buf_pkg::*;
#(
    parameter int DEPTH = INST_BUF_DEPTH
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             rom_ce_o;
    inst_addr_t       rom_addr_o;
    inst_t            rom_data_i;
    logic             flush_i;
    inst_addr_t       flush_pc_i;
    logic             id_valid_o;
    logic             id_ready_i;
    inst_addr_t       id_pc_o;
    inst_t            id_inst_o;
    logic [CNT_W-1:0] fifo_cnt_o;

    modport master (
        output rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, fifo_cnt_o,
        input  rom_data_i, flush_i, flush_pc_i, id_ready_i
    );

    modport slave (
        input  rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, fifo_cnt_o,
        output rom_data_i, flush_i, flush_pc_i, id_ready_i
    );

endinterface

// File: rtl/inst_fetch_fifo.sv
// Synchronous prefetch FIFO with combinational head read and a single-cycle clear.
// Storage has no reset so it can map onto distributed RAM; only pointers/count reset.
module inst_fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    always_ff @(posedge clk) begin
        if (push && !rst && !clear) begin
            mem[wptr] <= wdata;
        end
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !clear) begin
            assert (!(push && !pop && count == CW'(DEPTH)));
            assert (!(pop && count == '0));
        end
    end

    assign head = mem[rptr];

endmodule

// File: rtl/inst_fetch_buf.sv
// Fetch PC generator, ROM interface and decode handshake around a prefetch FIFO.
// A fetch is issued in every running cycle that has (or is freeing) a free slot.
module inst_fetch_buf
    import inst_fetch_buf_pkg::*;
#(
    parameter inst_addr_t RESET_PC = 32'h0000_0000,
    parameter int         DEPTH    = INST_BUF_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    inst_fetch_buf_if.master        bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state;
    inst_addr_t    fetch_pc;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  wr_entry;
    logic          head_vld;
    logic          full;
    logic          deq;
    logic          enq;

    assign full     = (count == CW'(DEPTH));
    assign head_vld = !rst && (count != '0) && !bus.flush_i;
    assign deq      = head_vld && bus.id_ready_i;
    // a full FIFO still fetches when the head leaves in the same cycle
    assign enq      = (state == F_RUN) && !rst && !bus.flush_i && (!full || deq);
    assign wr_entry = '{pc: fetch_pc, inst: bus.rom_data_i};

    inst_fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (bus.flush_i),
        .push  (enq),
        .pop   (deq),
        .wdata (wr_entry),
        .head  (head),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state    <= F_IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            case (state)
                F_IDLE:  state <= F_RUN;
                F_RUN:   state <= F_RUN;
                default: state <= F_IDLE;
            endcase
            if (bus.flush_i) begin
                fetch_pc <= align_word(bus.flush_pc_i);
            end else if (enq) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

    assign bus.rom_ce_o   = enq;
    assign bus.rom_addr_o = rst ? RESET_PC : fetch_pc;
    assign bus.id_valid_o = head_vld;
    assign bus.id_pc_o    = rst ? '0 : head.pc;
    assign bus.id_inst_o  = rst ? '0 : head.inst;
    assign bus.fifo_cnt_o = rst ? '0 : count;

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Directed-vector bench for inst_fetch_buf: one record per clock cycle plus
// a hand-written back-to-back flush sequence.
module tb_inst_fetch_buf;

    localparam logic [31:0] KEY = 32'hDEAD_0000;

    typedef struct {
        logic        rst;
        logic        flush;
        logic [31:0] fpc;
        logic        rdy;
        logic        ce;
        logic [31:0] addr;
        logic        vld;
        logic        hd;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    vec_t vt[$];

    inst_fetch_buf_if #(.DEPTH(4)) bus ();

    inst_fetch_buf #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ROM model: word at address A is A ^ DEAD_0000
    assign bus.rom_data_i = bus.rom_addr_o ^ KEY;

    function automatic void add(input logic r, input logic f, input logic [31:0] fp,
                                input logic rd, input logic ce, input logic [31:0] addr,
                                input logic vld, input logic hd, input logic [31:0] pc,
                                input int cnt);
        vec_t v;
        v.rst = r; v.flush = f; v.fpc = fp; v.rdy = rd;
        v.ce = ce; v.addr = addr; v.vld = vld; v.hd = hd; v.pc = pc;
        v.inst = r ? 32'h0 : (pc ^ KEY);
        v.cnt = 32'(cnt);
        vt.push_back(v);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %h want %h", nm, idx, act, exp);
        end
    endtask

    initial begin
        bit seen;
        // startup: 3 reset cycles, ready high
        for (int i = 0; i < 3; i++) add(1,0,0,1, 0,32'h0,0,1,32'h0,0);
        add(0,0,0,1, 0,32'h0,0,0,32'h0,0);
        add(0,0,0,1, 1,32'h0,0,0,32'h0,0);
        add(0,0,0,1, 1,32'h4,1,1,32'h0,1);
        add(0,0,0,1, 1,32'h8,1,1,32'h4,1);
        add(0,0,0,1, 1,32'hC,1,1,32'h8,1);
        // backpressure from reset, then full + single-cycle dequeue
        add(1,0,0,0, 0,32'h0,0,1,32'h0,0);
        add(0,0,0,0, 0,32'h0,0,0,32'h0,0);
        add(0,0,0,0, 1,32'h0,0,0,32'h0,0);
        add(0,0,0,0, 1,32'h4,1,1,32'h0,1);
        add(0,0,0,0, 1,32'h8,1,1,32'h0,2);
        add(0,0,0,0, 1,32'hC,1,1,32'h0,3);
        add(0,0,0,0, 0,32'h10,1,1,32'h0,4);
        add(0,0,0,0, 0,32'h10,1,1,32'h0,4);
        add(0,0,0,1, 1,32'h10,1,1,32'h0,4);
        add(0,0,0,0, 0,32'h14,1,1,32'h4,4);
        add(0,0,0,1, 1,32'h14,1,1,32'h4,4);
        add(0,0,0,1, 1,32'h18,1,1,32'h8,4);
        add(0,0,0,1, 1,32'h1C,1,1,32'hC,4);
        add(0,0,0,1, 1,32'h20,1,1,32'h10,4);
        add(0,0,0,0, 0,32'h24,1,1,32'h14,4);
        // flush with three entries queued
        add(1,0,0,0, 0,32'h0,0,1,32'h0,0);
        add(0,0,0,0, 0,32'h0,0,0,32'h0,0);
        add(0,0,0,0, 1,32'h0,0,0,32'h0,0);
        add(0,0,0,0, 1,32'h4,1,1,32'h0,1);
        add(0,0,0,0, 1,32'h8,1,1,32'h0,2);
        add(0,1,32'h103,0, 0,32'hC,0,0,32'h0,3);
        add(0,0,0,1, 1,32'h100,0,0,32'h0,0);
        add(0,0,0,1, 1,32'h104,1,1,32'h100,1);
        add(0,0,0,1, 1,32'h108,1,1,32'h104,1);
        // address wrap, then reset (also asserting flush) with two entries queued
        add(0,1,32'hFFFF_FFF8,1, 0,32'h10C,0,0,32'h0,1);
        add(0,0,0,0, 1,32'hFFFF_FFF8,0,0,32'h0,0);
        add(0,0,0,0, 1,32'hFFFF_FFFC,1,1,32'hFFFF_FFF8,1);
        add(0,0,0,1, 1,32'h0,1,1,32'hFFFF_FFF8,2);
        add(0,0,0,1, 1,32'h4,1,1,32'hFFFF_FFFC,2);
        add(0,0,0,1, 1,32'h8,1,1,32'h0,2);
        add(1,1,32'h500,0, 0,32'h0,0,1,32'h0,0);
        add(0,0,0,1, 0,32'h0,0,0,32'h0,0);
        add(0,0,0,1, 1,32'h0,0,0,32'h0,0);
        add(0,0,0,1, 1,32'h4,1,1,32'h0,1);

        foreach (vt[i]) begin
            rst            = vt[i].rst;
            bus.flush_i    = vt[i].flush;
            bus.flush_pc_i = vt[i].fpc;
            bus.id_ready_i = vt[i].rdy;
            @(negedge clk);
            chk("rom_ce",   i, 32'(bus.rom_ce_o),   32'(vt[i].ce));
            chk("rom_addr", i, bus.rom_addr_o,      vt[i].addr);
            chk("id_valid", i, 32'(bus.id_valid_o), 32'(vt[i].vld));
            chk("fifo_cnt", i, 32'(bus.fifo_cnt_o), vt[i].cnt);
            if (vt[i].hd) begin
                chk("id_pc",   i, bus.id_pc_o,   vt[i].pc);
                chk("id_inst", i, bus.id_inst_o, vt[i].inst);
            end
            @(posedge clk); #1;
        end

        // back-to-back flushes: the second target wins
        bus.flush_i = 1'b1; bus.flush_pc_i = 32'h200; bus.id_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_pc_i = 32'h302;
        @(negedge clk);
        chk("dbl_flush_vld", 100, 32'(bus.id_valid_o), 32'h0);
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        @(negedge clk);
        chk("dbl_flush_ce",   101, 32'(bus.rom_ce_o), 32'h1);
        chk("dbl_flush_addr", 101, bus.rom_addr_o,    32'h300);
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (bus.id_valid_o) begin
                seen = 1'b1;
                chk("dbl_flush_pc",   102, bus.id_pc_o,   32'h300);
                chk("dbl_flush_inst", 102, bus.id_inst_o, 32'h300 ^ KEY);
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL dbl_flush_timeout got no valid want valid within 8 cycles");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
